// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: accepts two coin values, vends one item, returns change.
// Optional refund-on-cancel is enabled by defining VEND_CTRL_CANCEL_EN.
module vend_ctrl #(
    parameter int COIN_A     = 10,
    parameter int COIN_B     = 50,
    parameter int PRICE      = 40,
    parameter int MAX_CREDIT = 90,
    parameter int CW         = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_a,
    input  logic          coin_b,
    input  logic          buy,
    input  logic          cancel,
    output logic [CW-1:0] credit,
    output logic          vend,
    output logic          chg,
    output logic          rej,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    // One extra bit so credit + COIN_B never wraps before the limit check.
    localparam logic [CW:0]   COIN_A_X = (CW+1)'(COIN_A);
    localparam logic [CW:0]   COIN_B_X = (CW+1)'(COIN_B);
    localparam logic [CW:0]   PRICE_X  = (CW+1)'(PRICE);
    localparam logic [CW:0]   MAX_X    = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] COIN_A_C = CW'(COIN_A);
    localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);

    state_t      state;
    logic [CW:0] cur;
    logic [CW:0] after_b;
    logic [CW:0] after_a;
    logic [CW:0] coin_credit;
    logic        b_ok;
    logic        a_ok;
    logic        do_cancel;
    logic        coin_any;

`ifdef VEND_CTRL_CANCEL_EN
    assign do_cancel = cancel && (credit != '0);
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign do_cancel     = 1'b0;
`endif

    assign coin_any = coin_a || coin_b;

    // Large coin is judged first; small coin is judged against the result.
    always_comb begin
        cur         = {1'b0, credit};
        after_b     = cur + COIN_B_X;
        b_ok        = coin_b && (after_b <= MAX_X);
        coin_credit = b_ok ? after_b : cur;
        after_a     = coin_credit + COIN_A_X;
        a_ok        = coin_a && (after_a <= MAX_X);
        if (a_ok)
            coin_credit = after_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            credit <= '0;
            vend   <= 1'b0;
            chg    <= 1'b0;
            rej    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            vend <= 1'b0;
            chg  <= 1'b0;
            rej  <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_cancel) begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                        rej   <= coin_any;
                    end else if (buy && (cur >= PRICE_X)) begin
                        state <= VEND;
                        busy  <= 1'b1;
                        rej   <= coin_any;
                    end else begin
                        credit <= coin_credit[CW-1:0];
                        rej    <= (coin_b && !b_ok) || (coin_a && !a_ok);
                        busy   <= 1'b0;
                    end
                end
                VEND: begin
                    vend   <= 1'b1;
                    rej    <= coin_any;
                    credit <= credit - PRICE_C;
                    if (cur == PRICE_X) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= CHANGE;
                    end
                end
                CHANGE: begin
                    chg    <= 1'b1;
                    rej    <= coin_any;
                    credit <= credit - COIN_A_C;
                    if (cur == COIN_A_X) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter COIN_A, 10, value of the small coin and of the change coin; all other values SHALL be integer multiples of it.
REQ-002 Parameter COIN_B, 50, value of the large coin.
REQ-003 Parameter PRICE, 40, price of one item (> 0).
REQ-004 Parameter MAX_CREDIT, 90, maximum credit held (>= PRICE, >= COIN_B).
REQ-005 Parameter CW, 7, credit width; 2**CW SHALL exceed MAX_CREDIT.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 coin_a  input  1  one-cycle pulse, COIN_A coin inserted.
REQ-009 coin_b  input  1  one-cycle pulse, COIN_B coin inserted.
REQ-010 buy  input  1  one-cycle pulse, purchase request.
REQ-011 cancel  input  1  one-cycle pulse, refund request (VEND_CTRL_CANCEL_EN only).
REQ-012 credit  output  CW  current credit, registered.
REQ-013 vend  output  1  one-cycle pulse, item released.
REQ-014 chg  output  1  one-cycle pulse per COIN_A coin returned.
REQ-015 rej  output  1  one-cycle pulse, a coin was refused and returned at once.
REQ-016 busy  output  1  high in VEND and CHANGE states.

Function
REQ-017 States SHALL be IDLE, VEND, CHANGE; all outputs registered, one-cycle latency from input pulse to response.
REQ-018 IDLE, coin accepted: credit += coin value if result <= MAX_CREDIT; otherwise credit unchanged and rej=1.
REQ-019 coin_a and coin_b in same cycle: coin_b evaluated first, then coin_a against the updated credit; each refused coin raises rej (one pulse covers both).
REQ-020 IDLE, buy with credit >= PRICE: next state VEND; coins in that cycle refused (rej=1); credit unchanged.
REQ-021 IDLE, buy with credit < PRICE: ignored; coins in that cycle processed per REQ-018.
REQ-022 VEND (exactly one cycle): vend=1, credit <= credit - PRICE; next state CHANGE if remainder > 0, else IDLE.
REQ-023 CHANGE: each cycle chg=1 and credit -= COIN_A; when credit reaches 0, next state IDLE; chg pulses = remainder/COIN_A, back to back.
REQ-024 VEND/CHANGE: every coin refused (rej=1), buy and cancel ignored, busy=1.
REQ-025 credit SHALL never exceed MAX_CREDIT nor underflow below 0.

Reset
REQ-026 rst asserted at any time: state IDLE, credit=0, vend=chg=rej=busy=0; any change in progress is abandoned, no further chg pulses.
REQ-027 First edge after rst deasserts SHALL behave as IDLE with zero credit.

Configuration
REQ-028 Macro VEND_CTRL_CANCEL_EN defined: in IDLE, cancel with credit > 0 enters CHANGE and refunds all credit per REQ-023; cancel with credit 0 ignored; cancel and buy in same cycle: cancel wins, buy dropped.
REQ-029 Macro VEND_CTRL_CANCEL_EN undefined: cancel port present but ignored; credit returned only via purchase change.

Verification
REQ-030 Defaults: coin_b, buy -> vend pulse on cycle 2 after buy, one chg pulse, credit 50->10->0, return to IDLE.
REQ-031 Four coin_a then buy -> credit 40, vend, zero chg pulses, busy high exactly one cycle.
REQ-032 coin_b, coin_a x4 (credit 90), coin_a -> rej=1, credit stays 90; coin_a+coin_b same cycle from 50 -> coin_b refused, coin_a accepted, credit 60, rej=1.
REQ-033 coin_b, buy, coin_a during CHANGE -> rej=1, credit path 50->10->0 unaffected.
REQ-034 CANCEL_EN: coin_a x3, cancel+buy same cycle -> no vend, three chg pulses, credit 30->0; without macro -> credit stays 30.
REQ-035 coin_b x1 + coin_a x4 (90), buy, rst asserted during CHANGE after 2 chg -> credit 0, chg stops, IDLE.
